pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central hazard/sequencing controller for the 5-stage core. Drives execute-stage forwarding selects and
//  per-register stall/flush for IF/ID, ID/EX, EX/MEM, MEM/WB. Sequences the multi-cycle MDU through a handshake.
//  Arbitrates load-use, taken branch/jump, data-memory wait and trap redirect.
// PARAMETERS
//  REG_AW       5   register address width
//  MDU_TIMEOUT  64  max cycles waiting for mdu_done_i before forced exit; 0 = watchdog disabled
// PORTS
//  clk_i           in   1       clock
//  rst_i           in   1       asynchronous reset, active-high
//  id_rs1_addr_i   in   REG_AW  rs1 of instr in ID
//  id_rs2_addr_i   in   REG_AW  rs2 of instr in ID
//  id_uses_rs1_i   in   1       ID instr reads rs1
//  id_uses_rs2_i   in   1       ID instr reads rs2
//  ex_rs1_addr_i   in   REG_AW  rs1 of instr in EX (ID/EX reg)
//  ex_rs2_addr_i   in   REG_AW  rs2 of instr in EX (ID/EX reg)
//  ex_rd_addr_i    in   REG_AW  rd of instr in EX
//  ex_is_load_i    in   1       EX instr is a load
//  ex_mdu_op_i     in   1       EX instr is a mul/div
//  mem_write_rd_i  in   1       EX/MEM instr writes rd
//  mem_rd_addr_i   in   REG_AW  EX/MEM rd
//  wb_write_rd_i   in   1       MEM/WB instr writes rd
//  wb_rd_addr_i    in   REG_AW  MEM/WB rd
//  new_pc_en_i     in   1       taken branch/jump from execute (already masked by its stall/flush)
//  mem_busy_i      in   1       data memory not ready this cycle
//  trap_i          in   1       trap committed in WB this cycle
//  mdu_done_i      in   1       MDU result valid, 1-cycle pulse
//  forward_rs1_o   out  2       0=regfile, 1=MEM/WB data, 2=EX/MEM data
//  forward_rs2_o   out  2       same encoding for rs2
//  stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o  out 1 each: hold register (PC holds with IF/ID)
//  flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o  out 1 each: load bubble; flush beats stall
//  mdu_start_o     out  1       1-cycle pulse launching MDU on EX operands
//  mdu_abort_o     out  1       1-cycle pulse cancelling in-flight MDU op
//  mdu_timeout_o   out  1       1-cycle pulse on watchdog expiry
//  trap_redirect_o out  1       1-cycle pulse: fetch loads trap vector
// BEHAVIOUR
//  Reset: state=RUN, done_q=0, wdog=0. While rst_i: all flush_*=1, all stall_*=0, pulses 0, forward_*=0.
//  Forwarding (comb, any state): rsX==0 -> 0. Else match with mem_write_rd_i -> 2. Else match with wb_write_rd_i -> 1. Else 0.
//  FSM states RUN, MDU_BUSY. Per-cycle priority, highest first:
//   1 trap_i: flush all four regs, trap_redirect_o=1; in MDU_BUSY also mdu_abort_o=1, clear done_q/wdog; next=RUN.
//   2 mem_busy_i: stall IF/ID, ID/EX, EX/MEM; flush MEM/WB. In MDU_BUSY latch mdu_done_i into done_q; no start.
//   3 RUN & ex_mdu_op_i: mdu_start_o=1, stall IF/ID+ID/EX, flush EX/MEM; next=MDU_BUSY, wdog=0.
//   4 MDU_BUSY & (mdu_done_i|done_q): no stall/flush, EX/MEM captures result; next=RUN, done_q=0.
//   5 MDU_BUSY, no done: stall IF/ID+ID/EX, flush EX/MEM; wdog++.
//      At wdog==MDU_TIMEOUT-1 (if MDU_TIMEOUT!=0): mdu_timeout_o=1, mdu_abort_o=1, exit as in 4.
//   6 RUN & new_pc_en_i: flush IF/ID and ID/EX (2 wrong-path instrs).
//   7 RUN load-use: ex_is_load_i & ex_rd!=0 & (uses_rs1&id_rs1==ex_rd | uses_rs2&id_rs2==ex_rd):
//      stall IF/ID, flush ID/EX. Exactly 1 bubble.
//   else: no stall/flush.
//  Only one rule applies per cycle. Load-use and branch are ignored in MDU_BUSY (ID held anyway).
//  Branch during mem_busy: execute masks it, so no action.
//  Stall/flush are combinational from state+inputs (0-cycle latency). mdu_start_o fires once per MDU instr.
//  It cannot refire on the exit cycle because start issues only from RUN.
//  Async reset mid-MDU: state->RUN immediately, no abort pulse (MDU is reset by same rst_i).
// TESTING
//  lw x5; add x6,x5,x1 -> load-use: 1 cycle stall_if_id_o=1 & flush_id_ex_o=1, then forward_rs1_o=1 for add.
//  add x5; add x7,x5,x5 back-to-back -> forward_rs1_o=forward_rs2_o=2, no stall; rd=x0 -> forward=0.
//  mul in EX, mdu_done_i at cycle 5 -> mdu_start_o 1 pulse; 4 cycles stall_id_ex_o=1+flush_ex_mem_o=1; RUN on cycle 5.
//  mdu_done_i during mem_busy_i -> done_q set; MDU_BUSY exits first cycle mem_busy_i=0; no second start.
//  trap_i in MDU_BUSY with new_pc_en_i=1 -> all flush_*=1, trap_redirect_o & mdu_abort_o pulse; branch ignored.
//  MDU_TIMEOUT=8, no done -> mdu_timeout_o+mdu_abort_o on 8th busy cycle, state RUN; rst_i mid-busy -> RUN, flush all.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for the 5-stage core: execute-stage forwarding,
// per-register stall/flush, multi-cycle MDU handshake with watchdog, and trap redirect.
module pipeline_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MDU_TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              id_uses_rs1_i,
    input  logic              id_uses_rs2_i,
    input  logic [REG_AW-1:0] ex_rs1_addr_i,
    input  logic [REG_AW-1:0] ex_rs2_addr_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic              ex_is_load_i,
    input  logic              ex_mdu_op_i,
    input  logic              mem_write_rd_i,
    input  logic [REG_AW-1:0] mem_rd_addr_i,
    input  logic              wb_write_rd_i,
    input  logic [REG_AW-1:0] wb_rd_addr_i,
    input  logic              new_pc_en_i,
    input  logic              mem_busy_i,
    input  logic              trap_i,
    input  logic              mdu_done_i,
    output logic [1:0]        forward_rs1_o,
    output logic [1:0]        forward_rs2_o,
    output logic              stall_if_id_o,
    output logic              stall_id_ex_o,
    output logic              stall_ex_mem_o,
    output logic              stall_mem_wb_o,
    output logic              flush_if_id_o,
    output logic              flush_id_ex_o,
    output logic              flush_ex_mem_o,
    output logic              flush_mem_wb_o,
    output logic              mdu_start_o,
    output logic              mdu_abort_o,
    output logic              mdu_timeout_o,
    output logic              trap_redirect_o
);

    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MDU_BUSY = 1'b1;

    localparam int WDW = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [WDW-1:0] WDOG_LAST = (MDU_TIMEOUT == 0) ? '0 : WDW'(MDU_TIMEOUT - 1);
    localparam logic WDOG_EN = (MDU_TIMEOUT != 0);

    logic [0:0]     state_q, state_d;
    logic           done_q, done_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           load_use_s;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              mem_wr,
        input logic [REG_AW-1:0] mem_rd,
        input logic              wb_wr,
        input logic [REG_AW-1:0] wb_rd
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (rs == '0) begin
            sel = 2'd0;
        end else if (mem_wr && (mem_rd == rs)) begin
            sel = 2'd2;
        end else if (wb_wr && (wb_rd == rs)) begin
            sel = 2'd1;
        end else begin
            sel = 2'd0;
        end
        return sel;
    endfunction

    function automatic logic load_use_hit(
        input logic              is_load,
        input logic [REG_AW-1:0] ex_rd,
        input logic              uses1,
        input logic [REG_AW-1:0] rs1,
        input logic              uses2,
        input logic [REG_AW-1:0] rs2
    );
        return is_load && (ex_rd != '0) &&
               ((uses1 && (rs1 == ex_rd)) || (uses2 && (rs2 == ex_rd)));
    endfunction

    assign load_use_s = load_use_hit(ex_is_load_i, ex_rd_addr_i, id_uses_rs1_i, id_rs1_addr_i,
                                     id_uses_rs2_i, id_rs2_addr_i);

    // Forwarding selects; the youngest producer (EX/MEM) wins over MEM/WB.
    always_comb begin
        forward_rs1_o = 2'd0;
        forward_rs2_o = 2'd0;
        if (rst_i) begin
            forward_rs1_o = 2'd0;
            forward_rs2_o = 2'd0;
        end else begin
            forward_rs1_o = fwd_sel(ex_rs1_addr_i, mem_write_rd_i, mem_rd_addr_i,
                                    wb_write_rd_i, wb_rd_addr_i);
            forward_rs2_o = fwd_sel(ex_rs2_addr_i, mem_write_rd_i, mem_rd_addr_i,
                                    wb_write_rd_i, wb_rd_addr_i);
        end
    end

    // Priority-ordered hazard arbitration and MDU sequencing; exactly one rule per cycle.
    always_comb begin
        state_d         = state_q;
        done_d          = done_q;
        wdog_d          = wdog_q;
        stall_if_id_o   = 1'b0;
        stall_id_ex_o   = 1'b0;
        stall_ex_mem_o  = 1'b0;
        stall_mem_wb_o  = 1'b0;
        flush_if_id_o   = 1'b0;
        flush_id_ex_o   = 1'b0;
        flush_ex_mem_o  = 1'b0;
        flush_mem_wb_o  = 1'b0;
        mdu_start_o     = 1'b0;
        mdu_abort_o     = 1'b0;
        mdu_timeout_o   = 1'b0;
        trap_redirect_o = 1'b0;

        if (rst_i) begin
            flush_if_id_o  = 1'b1;
            flush_id_ex_o  = 1'b1;
            flush_ex_mem_o = 1'b1;
            flush_mem_wb_o = 1'b1;
            state_d        = ST_RUN;
            done_d         = 1'b0;
            wdog_d         = '0;
        end else if (trap_i) begin
            flush_if_id_o   = 1'b1;
            flush_id_ex_o   = 1'b1;
            flush_ex_mem_o  = 1'b1;
            flush_mem_wb_o  = 1'b1;
            trap_redirect_o = 1'b1;
            if (state_q == ST_MDU_BUSY) begin
                mdu_abort_o = 1'b1;
                done_d      = 1'b0;
                wdog_d      = '0;
            end else begin
                mdu_abort_o = 1'b0;
            end
            state_d = ST_RUN;
        end else if (mem_busy_i) begin
            stall_if_id_o  = 1'b1;
            stall_id_ex_o  = 1'b1;
            stall_ex_mem_o = 1'b1;
            flush_mem_wb_o = 1'b1;
            // A done pulse arriving while memory is stalled must not be lost.
            if ((state_q == ST_MDU_BUSY) && mdu_done_i) begin
                done_d = 1'b1;
            end else begin
                done_d = done_q;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (ex_mdu_op_i) begin
                        mdu_start_o    = 1'b1;
                        stall_if_id_o  = 1'b1;
                        stall_id_ex_o  = 1'b1;
                        flush_ex_mem_o = 1'b1;
                        state_d        = ST_MDU_BUSY;
                        wdog_d         = '0;
                        done_d         = 1'b0;
                    end else if (new_pc_en_i) begin
                        flush_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else if (load_use_s) begin
                        stall_if_id_o = 1'b1;
                        flush_id_ex_o = 1'b1;
                    end else begin
                        stall_if_id_o = 1'b0;
                    end
                end
                ST_MDU_BUSY: begin
                    if (mdu_done_i || done_q) begin
                        state_d = ST_RUN;
                        done_d  = 1'b0;
                    end else if (WDOG_EN && (wdog_q == WDOG_LAST)) begin
                        // Watchdog exit releases the pipeline like a normal completion.
                        mdu_timeout_o = 1'b1;
                        mdu_abort_o   = 1'b1;
                        state_d       = ST_RUN;
                        done_d        = 1'b0;
                        wdog_d        = '0;
                    end else begin
                        stall_if_id_o  = 1'b1;
                        stall_id_ex_o  = 1'b1;
                        flush_ex_mem_o = 1'b1;
                        wdog_d         = wdog_q + WDW'(1);
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    done_d  = 1'b0;
                    wdog_d  = '0;
                end
            endcase
        end
    end

    // Controller state, latched MDU completion and watchdog count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
            done_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            wdog_q  <= wdog_d;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios followed by
// randomized traffic, all compared against a rule-table reference model.
module tb_pipeline_ctrl;

    localparam int AW = 5;
    localparam int TO = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [AW-1:0] id_rs1_addr_i, id_rs2_addr_i, ex_rs1_addr_i, ex_rs2_addr_i, ex_rd_addr_i;
    logic [AW-1:0] mem_rd_addr_i, wb_rd_addr_i;
    logic          id_uses_rs1_i, id_uses_rs2_i, ex_is_load_i, ex_mdu_op_i;
    logic          mem_write_rd_i, wb_write_rd_i, new_pc_en_i, mem_busy_i, trap_i, mdu_done_i;
    logic [1:0]    forward_rs1_o, forward_rs2_o;
    logic          stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o;
    logic          flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o;
    logic          mdu_start_o, mdu_abort_o, mdu_timeout_o, trap_redirect_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: busy flag, latched completion, busy cycles without done.
    bit m_busy, m_done;
    int m_cnt;
    bit n_busy, n_done;
    int n_cnt;

    pipeline_ctrl #(.REG_AW(AW), .MDU_TIMEOUT(TO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_is_load_i(ex_is_load_i), .ex_mdu_op_i(ex_mdu_op_i),
        .mem_write_rd_i(mem_write_rd_i), .mem_rd_addr_i(mem_rd_addr_i),
        .wb_write_rd_i(wb_write_rd_i), .wb_rd_addr_i(wb_rd_addr_i),
        .new_pc_en_i(new_pc_en_i), .mem_busy_i(mem_busy_i), .trap_i(trap_i),
        .mdu_done_i(mdu_done_i),
        .forward_rs1_o(forward_rs1_o), .forward_rs2_o(forward_rs2_o),
        .stall_if_id_o(stall_if_id_o), .stall_id_ex_o(stall_id_ex_o),
        .stall_ex_mem_o(stall_ex_mem_o), .stall_mem_wb_o(stall_mem_wb_o),
        .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
        .flush_ex_mem_o(flush_ex_mem_o), .flush_mem_wb_o(flush_mem_wb_o),
        .mdu_start_o(mdu_start_o), .mdu_abort_o(mdu_abort_o),
        .mdu_timeout_o(mdu_timeout_o), .trap_redirect_o(trap_redirect_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_fwd(input int rs);
        if (rs == 0) return 0;
        if (mem_write_rd_i && (int'(mem_rd_addr_i) == rs)) return 2;
        if (wb_write_rd_i && (int'(wb_rd_addr_i) == rs)) return 1;
        return 0;
    endfunction

    // Expected vector {fwd1,fwd2,stall[ifid,idex,exmem,memwb],flush[...],start,abort,timeout,redirect}.
    task automatic model_eval(output logic [15:0] v);
        int rule;
        logic [3:0] st, fl;
        logic start, abort, tmo, redir;
        bit lu;
        lu = ex_is_load_i && (ex_rd_addr_i != 0) &&
             ((id_uses_rs1_i && id_rs1_addr_i == ex_rd_addr_i) ||
              (id_uses_rs2_i && id_rs2_addr_i == ex_rd_addr_i));
        if (rst_i)                           rule = 99;
        else if (trap_i)                     rule = 1;
        else if (mem_busy_i)                 rule = 2;
        else if (!m_busy && ex_mdu_op_i)     rule = 3;
        else if (m_busy && (mdu_done_i || m_done)) rule = 4;
        else if (m_busy && m_cnt == TO - 1)  rule = 50;
        else if (m_busy)                     rule = 5;
        else if (new_pc_en_i)                rule = 6;
        else if (lu)                         rule = 7;
        else                                 rule = 0;
        st = 4'b0000; fl = 4'b0000; start = 0; abort = 0; tmo = 0; redir = 0;
        n_busy = m_busy; n_done = m_done; n_cnt = m_cnt;
        case (rule)
            99: begin fl = 4'b1111; n_busy = 0; n_done = 0; n_cnt = 0; end
            1:  begin fl = 4'b1111; redir = 1; abort = m_busy; n_busy = 0;
                      if (m_busy) begin n_done = 0; n_cnt = 0; end end
            2:  begin st = 4'b1110; fl = 4'b0001; if (m_busy && mdu_done_i) n_done = 1; end
            3:  begin st = 4'b1100; fl = 4'b0010; start = 1; n_busy = 1; n_cnt = 0; n_done = 0; end
            4:  begin n_busy = 0; n_done = 0; end
            50: begin tmo = 1; abort = 1; n_busy = 0; n_done = 0; n_cnt = 0; end
            5:  begin st = 4'b1100; fl = 4'b0010; n_cnt = m_cnt + 1; end
            6:  fl = 4'b1100;
            7:  begin st = 4'b1000; fl = 4'b0100; end
            default: ;
        endcase
        if (rst_i) v = {2'd0, 2'd0, st, fl, start, abort, tmo, redir};
        else v = {2'(exp_fwd(int'(ex_rs1_addr_i))), 2'(exp_fwd(int'(ex_rs2_addr_i))),
                  st, fl, start, abort, tmo, redir};
    endtask

    // One cycle: compare on the falling edge, advance the model after the rising edge.
    task automatic tick();
        logic [15:0] exp_v, got_v;
        @(negedge clk_i);
        model_eval(exp_v);
        got_v = {forward_rs1_o, forward_rs2_o,
                 stall_if_id_o, stall_id_ex_o, stall_ex_mem_o, stall_mem_wb_o,
                 flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o,
                 mdu_start_o, mdu_abort_o, mdu_timeout_o, trap_redirect_o};
        chk("ctl", 32'(got_v), 32'(exp_v));
        @(posedge clk_i);
        m_busy = n_busy; m_done = n_done; m_cnt = n_cnt;
        #1;
    endtask

    task automatic idle();
        id_rs1_addr_i = '0; id_rs2_addr_i = '0; ex_rs1_addr_i = '0; ex_rs2_addr_i = '0;
        ex_rd_addr_i = '0; mem_rd_addr_i = '0; wb_rd_addr_i = '0;
        id_uses_rs1_i = 0; id_uses_rs2_i = 0; ex_is_load_i = 0; ex_mdu_op_i = 0;
        mem_write_rd_i = 0; wb_write_rd_i = 0; new_pc_en_i = 0; mem_busy_i = 0;
        trap_i = 0; mdu_done_i = 0;
    endtask

    initial begin
        m_busy = 0; m_done = 0; m_cnt = 0;
        idle();
        rst_i = 1'b1;
        ex_rs1_addr_i = 5'd3; mem_write_rd_i = 1; mem_rd_addr_i = 5'd3; ex_mdu_op_i = 1;
        #2;
        chk("rst_flush_all", {flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o}, 4'hF);
        chk("rst_fwd", forward_rs1_o, 2'd0);
        chk("rst_start", mdu_start_o, 1'b0);
        tick();
        rst_i = 1'b0; idle();
        tick();

        // Load-use: one bubble, then forward from MEM/WB.
        ex_is_load_i = 1; ex_rd_addr_i = 5'd5; id_rs1_addr_i = 5'd5; id_uses_rs1_i = 1;
        id_rs2_addr_i = 5'd1; id_uses_rs2_i = 1;
        #2;
        chk("lu_stall_if_id", stall_if_id_o, 1'b1);
        chk("lu_flush_id_ex", flush_id_ex_o, 1'b1);
        tick();
        idle(); ex_rs1_addr_i = 5'd5; ex_rs2_addr_i = 5'd1; wb_write_rd_i = 1; wb_rd_addr_i = 5'd5;
        #2;
        chk("lu_fwd_rs1", forward_rs1_o, 2'd1);
        chk("lu_no_stall", stall_if_id_o, 1'b0);
        tick();

        // Back-to-back ALU: forward from EX/MEM; x0 never forwards.
        idle(); ex_rs1_addr_i = 5'd5; ex_rs2_addr_i = 5'd5; mem_write_rd_i = 1; mem_rd_addr_i = 5'd5;
        wb_write_rd_i = 1; wb_rd_addr_i = 5'd5;
        #2;
        chk("b2b_fwd", {forward_rs1_o, forward_rs2_o}, 4'b1010);
        tick();
        idle(); mem_write_rd_i = 1; wb_write_rd_i = 1;
        tick();

        // MUL: start, 4 busy cycles, done on cycle 5.
        idle(); ex_mdu_op_i = 1;
        #2;
        chk("mul_start", mdu_start_o, 1'b1);
        tick();
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("mul_busy_stall", {stall_id_ex_o, flush_ex_mem_o}, 2'b11);
            tick();
        end
        mdu_done_i = 1;
        #2;
        chk("mul_exit", {stall_id_ex_o, flush_ex_mem_o, mdu_start_o}, 3'b000);
        tick();
        idle(); tick();

        // Done during mem_busy is remembered; exit on first non-busy cycle, no restart.
        ex_mdu_op_i = 1; tick();
        tick();
        mem_busy_i = 1; mdu_done_i = 1; tick();
        mdu_done_i = 0; tick();
        mem_busy_i = 0;
        #2;
        chk("latched_done_exit", {stall_id_ex_o, flush_ex_mem_o, mdu_start_o}, 3'b000);
        tick();
        idle(); tick();

        // Trap during MDU with branch present.
        ex_mdu_op_i = 1; tick();
        tick();
        trap_i = 1; new_pc_en_i = 1;
        #2;
        chk("trap_busy", {flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o,
                          trap_redirect_o, mdu_abort_o}, 6'h3F);
        tick();
        idle(); tick();

        // Watchdog expiry on the 8th busy cycle, then back in RUN.
        ex_mdu_op_i = 1; tick();
        for (int i = 0; i < TO - 1; i++) tick();
        #2;
        chk("wdog_expire", {mdu_timeout_o, mdu_abort_o}, 2'b11);
        tick();
        #2;
        chk("wdog_run_again", mdu_start_o, 1'b1);
        tick();

        // Async reset while busy.
        tick();
        #1; rst_i = 1'b1; #1;
        chk("rst_mid_busy", {flush_if_id_o, flush_id_ex_o, flush_ex_mem_o, flush_mem_wb_o}, 4'hF);
        tick();
        rst_i = 1'b0;
        #2;
        chk("rst_then_start", mdu_start_o, 1'b1);
        tick();
        idle(); tick();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            rst_i          = ($urandom_range(299, 0) == 0);
            trap_i         = ($urandom_range(39, 0) == 0);
            mem_busy_i     = ($urandom_range(4, 0) == 0);
            ex_mdu_op_i    = ($urandom_range(9, 0) == 0) || (m_busy && $urandom_range(1, 0) == 0);
            mdu_done_i     = ($urandom_range(5, 0) == 0);
            new_pc_en_i    = ($urandom_range(5, 0) == 0);
            ex_is_load_i   = ($urandom_range(2, 0) == 0);
            id_uses_rs1_i  = 1'($urandom_range(1, 0));
            id_uses_rs2_i  = 1'($urandom_range(1, 0));
            mem_write_rd_i = 1'($urandom_range(1, 0));
            wb_write_rd_i  = 1'($urandom_range(1, 0));
            id_rs1_addr_i  = 5'($urandom_range(7, 0));
            id_rs2_addr_i  = 5'($urandom_range(7, 0));
            ex_rs1_addr_i  = 5'($urandom_range(7, 0));
            ex_rs2_addr_i  = 5'($urandom_range(7, 0));
            ex_rd_addr_i   = 5'($urandom_range(7, 0));
            mem_rd_addr_i  = 5'($urandom_range(7, 0));
            wb_rd_addr_i   = 5'($urandom_range(7, 0));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
